// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Radix-2 shift-add multiply, restoring divide, MAC and MTHI/MTLO.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_op_valid,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic             i_flush,
    output logic             o_op_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_MULT  = 4'h0;
    localparam logic [3:0] OP_MULTU = 4'h1;
    localparam logic [3:0] OP_DIV   = 4'h2;
    localparam logic [3:0] OP_DIVU  = 4'h3;
    localparam logic [3:0] OP_MTHI  = 4'h4;
    localparam logic [3:0] OP_MTLO  = 4'h5;
    localparam logic [3:0] OP_MADD  = 4'h6;
    localparam logic [3:0] OP_MADDU = 4'h7;
    localparam logic [3:0] OP_MSUB  = 4'h8;
    localparam logic [3:0] OP_MSUBU = 4'h9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_op;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rsh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rdiff;
    logic [2*WIDTH-1:0] w_step;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_res;

    assign w_accept = i_op_valid && !r_busy && !i_flush;

    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_signed = 1'b0;
        case (i_op)
            OP_MULT: begin
                w_is_mul = 1'b1;
                w_signed = 1'b1;
            end
            OP_MULTU: w_is_mul = 1'b1;
            OP_DIV: begin
                w_is_div = 1'b1;
                w_signed = 1'b1;
            end
            OP_DIVU: w_is_div = 1'b1;
            OP_MADD, OP_MSUB: begin
                w_is_mul = 1'b1;
                w_signed = 1'b1;
            end
            OP_MADDU, OP_MSUBU: w_is_mul = 1'b1;
            default: ;
        endcase
    end

    assign w_a_neg = w_signed && i_src_a[WIDTH-1];
    assign w_b_neg = w_signed && i_src_b[WIDTH-1];
    assign w_abs_a = w_a_neg ? -i_src_a : i_src_a;
    assign w_abs_b = w_b_neg ? -i_src_b : i_src_b;

    // One radix-2 step: multiply shifts right with carry, divide shifts left.
    always_comb begin
        w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                + (r_p[0] ? {1'b0, r_a} : '0);
        w_rsh   = r_p[2*WIDTH-1:WIDTH-1];
        w_ge    = (w_rsh >= {1'b0, r_b});
        w_rdiff = w_rsh[WIDTH-1:0] - r_b;
        if (r_is_div)
            w_step = {(w_ge ? w_rdiff : w_rsh[WIDTH-1:0]),
                      r_p[WIDTH-2:0], w_ge};
        else
            w_step = {w_sum, r_p[WIDTH-1:1]};
    end

    always_comb begin
        w_prod = r_neg_q ? -r_p : r_p;
        w_quo  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
        w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
        w_res  = w_prod;
        if (r_is_div) begin
            // r_a holds the raw dividend for divides.
            if (r_b == '0)
                w_res = {r_a, {WIDTH{1'b1}}};
            else
                w_res = {w_rem, w_quo};
        end else begin
            case (r_op)
                OP_MADD, OP_MADDU: w_res = {r_hi, r_lo} + w_prod;
                OP_MSUB, OP_MSUBU: w_res = {r_hi, r_lo} - w_prod;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && (w_is_mul || w_is_div)) w_state_nxt = S_RUN;
            S_RUN:  if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (i_op == OP_MTHI) r_hi <= i_src_a;
                        if (i_op == OP_MTLO) r_lo <= i_src_a;
                        if (w_is_mul || w_is_div) begin
                            r_op     <= i_op;
                            r_is_div <= w_is_div;
                            r_cnt    <= '0;
                            r_a      <= w_is_div ? i_src_a : w_abs_a;
                            r_b      <= w_abs_b;
                            r_p      <= {{WIDTH{1'b0}},
                                         (w_is_div ? w_abs_a : w_abs_b)};
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                        end
                    end
                end
                S_RUN: begin
                    if (!i_flush) begin
                        r_p   <= w_step;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    if (!i_flush) begin
                        r_hi   <= w_res[2*WIDTH-1:WIDTH];
                        r_lo   <= w_res[WIDTH-1:0];
                        r_done <= 1'b1;
                        r_dbz  <= r_is_div && (r_b == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_op_ready    = !r_busy;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule
